// File: rtl/count_event_monitor_if.sv
// Bus between the counter/control side and the event monitor.
// The monitor is the slave: it takes samples and control, and presents queued
// events on a valid/ready port.
//
// Event handshake: eventValid is high whenever the FIFO holds an event, and
// eventData shows the head. eventValid does not depend on eventReady. A pop
// happens only at a rising clock edge where eventValid && eventReady are both
// high. eventReady while eventValid is low has no effect.
interface count_event_monitor_if #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] countIn;
    logic             countValid;
    logic [WIDTH-1:0] cmpValue;
    logic             cmpLoad;
    logic             monitorEnable;
    logic             overflowClear;
    logic [WIDTH+1:0] eventData;
    logic             eventValid;
    logic             eventReady;
    logic             overflowFlag;
    logic [LW-1:0]    fifoLevel;

    modport master (
        output countIn, countValid, cmpValue, cmpLoad, monitorEnable,
               overflowClear, eventReady,
        input  eventData, eventValid, overflowFlag, fifoLevel
    );

    modport slave (
        input  countIn, countValid, cmpValue, cmpLoad, monitorEnable,
               overflowClear, eventReady,
        output eventData, eventValid, overflowFlag, fifoLevel
    );
endinterface

// File: rtl/count_event_monitor.sv
// Watches an up/down counter value, tags wrap-up, wrap-down and compare hits,
// and queues one tagged word {code, count} per classified sample in a small
// FIFO drained through a valid/ready port. Drops on a full FIFO set a sticky
// overflow flag.
module count_event_monitor #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic                    clock,
    input logic                    clearN,
    count_event_monitor_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_MATCH   = 2'b01;
    localparam logic [1:0] CODE_WRAP_UP = 2'b10;
    localparam logic [1:0] CODE_WRAP_DN = 2'b11;

    logic [WIDTH-1:0] cmp_reg;
    logic [WIDTH-1:0] prev_count;
    logic             prev_valid;
    logic [WIDTH+1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [LW-1:0]    level;
    logic             overflow;

    logic [1:0]       code;
    logic             sample_ok;
    logic             push;
    logic             pop;
    logic             full;
    logic             do_push;
    logic             drop;

    // Classify the current sample against the previous one and the old compare value.
    always_comb begin
        code      = CODE_NONE;
        sample_ok = bus.countValid & bus.monitorEnable & prev_valid;
        if (sample_ok) begin
            if (prev_count == MAX && bus.countIn == '0)
                code = CODE_WRAP_UP;
            else if (prev_count == '0 && bus.countIn == MAX)
                code = CODE_WRAP_DN;
            else if (bus.countIn == cmp_reg && bus.countIn != prev_count)
                code = CODE_MATCH;
        end
        push    = (code != CODE_NONE);
        pop     = (level != '0) && bus.eventReady;
        full    = (level == LW'(FIFO_DEPTH));
        // A full FIFO still accepts a push when the head leaves in the same edge.
        do_push = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Compare register and baseline tracking.
    always_ff @(posedge clock) begin
        if (!clearN) begin
            cmp_reg    <= '0;
            prev_count <= '0;
            prev_valid <= 1'b0;
        end else begin
            if (bus.cmpLoad)
                cmp_reg <= bus.cmpValue;
            if (!bus.monitorEnable) begin
                prev_valid <= 1'b0;
            end else if (bus.countValid) begin
                prev_count <= bus.countIn;
                prev_valid <= 1'b1;
            end
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!clearN) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {code, bus.countIn};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !pop)
                level <= level + LW'(1);
            else if (pop && !do_push)
                level <= level - LW'(1);
        end
    end

    // Sticky overflow: a drop in the same edge as a clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (!clearN)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (bus.overflowClear)
            overflow <= 1'b0;
    end

    assign bus.eventValid   = (level != '0);
    assign bus.eventData    = (level != '0) ? mem[rd_ptr] : '0;
    assign bus.overflowFlag = overflow;
    assign bus.fifoLevel    = level;
endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: reset, wrap detection, compare hits,
// compare-load race, overflow, full push+pop and head replacement.
module tb_count_event_monitor;
    logic clock;
    logic clearN;
    int   n_checks;
    int   n_fails;

    count_event_monitor_if #(.WIDTH(8), .FIFO_DEPTH(4)) bus ();

    count_event_monitor #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clock  (clock),
        .clearN (clearN),
        .bus    (bus.slave)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks: inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clearN = 1'b0;
        tick();
        clearN = 1'b1;
    endtask

    task automatic sample(input logic [7:0] v, input logic rdy);
        bus.countIn    = v;
        bus.countValid = 1'b1;
        bus.eventReady = rdy;
        tick();
        bus.countValid = 1'b0;
        bus.eventReady = 1'b0;
    endtask

    task automatic pop_one();
        bus.eventReady = 1'b1;
        tick();
        bus.eventReady = 1'b0;
    endtask

    task automatic load_cmp(input logic [7:0] v);
        bus.cmpValue = v;
        bus.cmpLoad  = 1'b1;
        tick();
        bus.cmpLoad  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.eventValid !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %0b expected 0", bus.eventValid); end
        n_checks++; if (bus.eventData !== 10'h000) begin n_fails++; $display("FAIL rst_data: got %h expected 000", bus.eventData); end
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL rst_level: got %0d expected 0", bus.fifoLevel); end
        n_checks++; if (bus.overflowFlag !== 1'b0) begin n_fails++; $display("FAIL rst_ovf: got %0b expected 0", bus.overflowFlag); end
        // Queue three events, then reset mid-stream together with a sample.
        bus.monitorEnable = 1'b1;
        sample(8'd255, 1'b0);
        sample(8'd0, 1'b0);
        sample(8'd255, 1'b0);
        sample(8'd0, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd3) begin n_fails++; $display("FAIL rst_pre_level: got %0d expected 3", bus.fifoLevel); end
        bus.countIn = 8'd255; bus.countValid = 1'b1; clearN = 1'b0;
        tick();
        bus.countValid = 1'b0; clearN = 1'b1;
        n_checks++; if (bus.eventValid !== 1'b0) begin n_fails++; $display("FAIL rst_mid_valid: got %0b expected 0", bus.eventValid); end
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL rst_mid_level: got %0d expected 0", bus.fifoLevel); end
        n_checks++; if (bus.overflowFlag !== 1'b0) begin n_fails++; $display("FAIL rst_mid_ovf: got %0b expected 0", bus.overflowFlag); end
        // First sample after reset is baseline only (255 after cleared prev 0 must not wrap).
        sample(8'd255, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL rst_baseline: got level %0d expected 0", bus.fifoLevel); end
        sample(8'd0, 1'b0);
        n_checks++; if (bus.eventData !== 10'h200) begin n_fails++; $display("FAIL rst_after_evt: got %h expected 200", bus.eventData); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.monitorEnable = 1'b1;
        sample(8'd254, 1'b0);
        sample(8'd255, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL wrap_no_evt: got level %0d expected 0", bus.fifoLevel); end
        sample(8'd0, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd1) begin n_fails++; $display("FAIL wrap_up_level: got %0d expected 1", bus.fifoLevel); end
        n_checks++; if (bus.eventData !== 10'h200) begin n_fails++; $display("FAIL wrap_up_data: got %h expected 200", bus.eventData); end
        pop_one();
        n_checks++; if (bus.eventValid !== 1'b0) begin n_fails++; $display("FAIL wrap_pop: got valid %0b expected 0", bus.eventValid); end
        sample(8'd0, 1'b0);
        sample(8'd255, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd1) begin n_fails++; $display("FAIL wrap_dn_level: got %0d expected 1", bus.fifoLevel); end
        n_checks++; if (bus.eventData !== 10'h3FF) begin n_fails++; $display("FAIL wrap_dn_data: got %h expected 3ff", bus.eventData); end
        // eventReady while empty must not disturb anything.
        pop_one();
        pop_one();
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL wrap_empty_pop: got level %0d expected 0", bus.fifoLevel); end
    endtask

    task automatic test_match();
        do_reset();
        bus.monitorEnable = 1'b1;
        load_cmp(8'd5);
        sample(8'd3, 1'b0);
        sample(8'd4, 1'b0);
        n_checks++; if (bus.eventValid !== 1'b0) begin n_fails++; $display("FAIL match_early: got valid %0b expected 0", bus.eventValid); end
        sample(8'd5, 1'b0);
        n_checks++; if (bus.eventValid !== 1'b1) begin n_fails++; $display("FAIL match_latency: got valid %0b expected 1", bus.eventValid); end
        n_checks++; if (bus.eventData !== 10'h105) begin n_fails++; $display("FAIL match_data: got %h expected 105", bus.eventData); end
        sample(8'd5, 1'b0);
        sample(8'd6, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd1) begin n_fails++; $display("FAIL match_once: got level %0d expected 1", bus.fifoLevel); end
    endtask

    task automatic test_cmp_race();
        do_reset();
        bus.monitorEnable = 1'b1;
        load_cmp(8'd7);
        sample(8'd6, 1'b0);
        bus.cmpValue = 8'd9; bus.cmpLoad = 1'b1;
        sample(8'd7, 1'b0);
        bus.cmpLoad = 1'b0;
        n_checks++; if (bus.eventData !== 10'h107) begin n_fails++; $display("FAIL race_old_cmp: got %h expected 107", bus.eventData); end
        pop_one();
        sample(8'd9, 1'b0);
        n_checks++; if (bus.eventData !== 10'h109) begin n_fails++; $display("FAIL race_new_cmp: got %h expected 109", bus.eventData); end
        n_checks++; if (bus.fifoLevel !== 3'd1) begin n_fails++; $display("FAIL race_level: got %0d expected 1", bus.fifoLevel); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q[$];
        logic [9:0] exp;
        do_reset();
        bus.monitorEnable = 1'b1;
        sample(8'd255, 1'b0);
        // Five events alternating wrap-up / wrap-down; the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                sample(8'd0, 1'b0);
                if (i < 4) exp_q.push_back(10'h200);
            end else begin
                sample(8'd255, 1'b0);
                if (i < 4) exp_q.push_back(10'h3FF);
            end
        end
        n_checks++; if (bus.fifoLevel !== 3'd4) begin n_fails++; $display("FAIL ovf_level: got %0d expected 4", bus.fifoLevel); end
        n_checks++; if (bus.overflowFlag !== 1'b1) begin n_fails++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflowFlag); end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_checks++; if (bus.eventData !== exp) begin n_fails++; $display("FAIL ovf_drain%0d: got %h expected %h", i, bus.eventData, exp); end
            pop_one();
        end
        n_checks++; if (bus.eventValid !== 1'b0) begin n_fails++; $display("FAIL ovf_empty: got valid %0b expected 0", bus.eventValid); end
        n_checks++; if (bus.overflowFlag !== 1'b1) begin n_fails++; $display("FAIL ovf_sticky: got %0b expected 1", bus.overflowFlag); end
        bus.overflowClear = 1'b1;
        tick();
        bus.overflowClear = 1'b0;
        n_checks++; if (bus.overflowFlag !== 1'b0) begin n_fails++; $display("FAIL ovf_clear: got %0b expected 0", bus.overflowFlag); end
    endtask

    task automatic test_full_push_pop();
        logic [9:0] exp_q[$];
        logic [9:0] exp;
        do_reset();
        bus.monitorEnable = 1'b1;
        sample(8'd255, 1'b0);
        sample(8'd0, 1'b0);   exp_q.push_back(10'h200);
        sample(8'd255, 1'b0); exp_q.push_back(10'h3FF);
        sample(8'd0, 1'b0);   exp_q.push_back(10'h200);
        sample(8'd255, 1'b0); exp_q.push_back(10'h3FF);
        n_checks++; if (bus.fifoLevel !== 3'd4) begin n_fails++; $display("FAIL full_level: got %0d expected 4", bus.fifoLevel); end
        // New event while full, with the head popping in the same edge.
        sample(8'd0, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(10'h200);
        n_checks++; if (bus.fifoLevel !== 3'd4) begin n_fails++; $display("FAIL full_pp_level: got %0d expected 4", bus.fifoLevel); end
        n_checks++; if (bus.overflowFlag !== 1'b0) begin n_fails++; $display("FAIL full_pp_ovf: got %0b expected 0", bus.overflowFlag); end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_checks++; if (bus.eventData !== exp) begin n_fails++; $display("FAIL full_drain%0d: got %h expected %h", i, bus.eventData, exp); end
            pop_one();
        end
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL full_end_level: got %0d expected 0", bus.fifoLevel); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.monitorEnable = 1'b1;
        sample(8'd255, 1'b0);
        sample(8'd0, 1'b0);
        // Level 1 with push and pop together: the head is replaced.
        sample(8'd255, 1'b1);
        n_checks++; if (bus.fifoLevel !== 3'd1) begin n_fails++; $display("FAIL b2b_level: got %0d expected 1", bus.fifoLevel); end
        n_checks++; if (bus.eventData !== 10'h3FF) begin n_fails++; $display("FAIL b2b_data: got %h expected 3ff", bus.eventData); end
    endtask

    task automatic test_disable();
        do_reset();
        bus.monitorEnable = 1'b1;
        sample(8'd255, 1'b0);
        bus.monitorEnable = 1'b0;
        sample(8'd0, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL dis_no_evt: got level %0d expected 0", bus.fifoLevel); end
        bus.monitorEnable = 1'b1;
        sample(8'd0, 1'b0);
        n_checks++; if (bus.fifoLevel !== 3'd0) begin n_fails++; $display("FAIL dis_rebaseline: got level %0d expected 0", bus.fifoLevel); end
        sample(8'd255, 1'b0);
        n_checks++; if (bus.eventData !== 10'h3FF) begin n_fails++; $display("FAIL dis_after: got %h expected 3ff", bus.eventData); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clearN            = 1'b0;
        bus.countIn       = '0;
        bus.countValid    = 1'b0;
        bus.cmpValue      = '0;
        bus.cmpLoad       = 1'b0;
        bus.monitorEnable = 1'b0;
        bus.overflowClear = 1'b0;
        bus.eventReady    = 1'b0;
        tick();
        test_reset();
        test_wrap();
        test_match();
        test_cmp_race();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
